// File: rtl/ctrl_pkg.sv
// Shared control-unit encodings: FSM states, opcode/funct values, mux selects and the control word.
package ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FN_W    = 6;
    localparam int unsigned ALU_W   = 3;
    localparam int unsigned SRCA_W  = 2;
    localparam int unsigned SRCB_W  = 3;
    localparam int unsigned PCS_W   = 2;
    localparam int unsigned ADR_W   = 2;
    localparam int unsigned CB_W    = 2;
    localparam int unsigned DST_W   = 2;
    localparam int unsigned M2R_W   = 3;
    localparam int unsigned EC_W    = 2;

    // Opcodes (IR[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [FN_W-1:0] FN_ADD = 6'h20;
    localparam logic [FN_W-1:0] FN_SUB = 6'h22;
    localparam logic [FN_W-1:0] FN_AND = 6'h24;

    // ALU operations
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b010;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b011;
    localparam logic [ALU_W-1:0] ALU_CMP = 3'b111;

    // ALU operand selects
    localparam logic [SRCA_W-1:0] SRCA_PC   = 2'b00;
    localparam logic [SRCA_W-1:0] SRCA_REGA = 2'b10;
    localparam logic [SRCB_W-1:0] SRCB_REGB   = 3'b000;
    localparam logic [SRCB_W-1:0] SRCB_FOUR   = 3'b001;
    localparam logic [SRCB_W-1:0] SRCB_IMM    = 3'b010;
    localparam logic [SRCB_W-1:0] SRCB_IMM_S2 = 3'b100;

    // PC source, memory address, branch condition
    localparam logic [PCS_W-1:0] PCS_ALU    = 2'b00;
    localparam logic [PCS_W-1:0] PCS_ALUOUT = 2'b01;
    localparam logic [PCS_W-1:0] PCS_JUMP   = 2'b10;
    localparam logic [PCS_W-1:0] PCS_MDR    = 2'b11;
    localparam logic [ADR_W-1:0] ADR_PC     = 2'b00;
    localparam logic [ADR_W-1:0] ADR_ALUOUT = 2'b01;
    localparam logic [ADR_W-1:0] ADR_EXC    = 2'b10;
    localparam logic [CB_W-1:0]  CB_EQ      = 2'b00;
    localparam logic [CB_W-1:0]  CB_NE      = 2'b01;

    // Register-file destination and write-back source
    localparam logic [DST_W-1:0] DST_RT     = 2'b00;
    localparam logic [DST_W-1:0] DST_RD     = 2'b01;
    localparam logic [M2R_W-1:0] M2R_ALUOUT = 3'b000;
    localparam logic [M2R_W-1:0] M2R_MDR    = 3'b001;

    // Exception causes
    localparam logic [EC_W-1:0] EC_NONE   = 2'b00;
    localparam logic [EC_W-1:0] EC_BAD_OP = 2'b01;
    localparam logic [EC_W-1:0] EC_OVF    = 2'b10;

    typedef enum logic [4:0] {
        ST_RESET,
        ST_FETCH,
        ST_FETCH_WAIT,
        ST_DECODE,
        ST_EXEC_R,
        ST_WB_R,
        ST_EXEC_I,
        ST_WB_I,
        ST_ADDR,
        ST_MEM_RD,
        ST_MEM_WAIT,
        ST_WB_LW,
        ST_MEM_WR,
        ST_BRANCH,
        ST_JUMP,
        ST_EXC_SAVE,
        ST_EXC_WAIT,
        ST_EXC_JUMP
    } state_t;

    // Full control word driven to the datapath
    typedef struct packed {
        logic              pc_w;
        logic              pc_write_cond;
        logic [CB_W-1:0]   cb;
        logic [PCS_W-1:0]  pc_source;
        logic [ADR_W-1:0]  iord;
        logic              mem_w;
        logic              mdr_w;
        logic              ir_w;
        logic              reg_ab_w;
        logic              alu_out_reg_w;
        logic              rb_w;
        logic              epc_w;
        logic [SRCA_W-1:0] alu_src_a;
        logic [SRCB_W-1:0] alu_src_b;
        logic [ALU_W-1:0]  alu_control;
        logic [DST_W-1:0]  reg_dst;
        logic [M2R_W-1:0]  mem_to_reg;
        logic [EC_W-1:0]   ec_ctrl;
    } ctrl_out_t;

    // R-type functions this core implements
    function automatic logic rtype_valid(input logic [FN_W-1:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND);
    endfunction

endpackage

// File: rtl/ctrl_unit.sv
// Multi-cycle MIPS-style control FSM with bad-opcode and overflow exceptions.
module ctrl_unit
    import ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W-1:0]   opcode,
    input  logic [FN_W-1:0]   funct,
    input  logic              Flag_Overflow,
    output logic              PC_W,
    output logic              PCWriteCond,
    output logic [CB_W-1:0]   CB,
    output logic [PCS_W-1:0]  PCSource,
    output logic [ADR_W-1:0]  IorD,
    output logic              Mem_W,
    output logic              MDR_W,
    output logic              IR_W,
    output logic              Reg_AB_W,
    output logic              ALU_Out_Reg_W,
    output logic              RB_W,
    output logic              EPC_W,
    output logic [SRCA_W-1:0] ALUSrcA,
    output logic [SRCB_W-1:0] ALUSrcB,
    output logic [ALU_W-1:0]  ALUControl,
    output logic [DST_W-1:0]  regDST,
    output logic [M2R_W-1:0]  MemToReg,
    output logic [EC_W-1:0]   EC_CTRL
);

    state_t          state, nxt_state;
    logic [EC_W-1:0] cause, nxt_cause;
    ctrl_out_t       out_q, nxt_out;

    // Moore output decode for one state; anything not set stays 0
    function automatic ctrl_out_t decode(input state_t st, input logic [EC_W-1:0] ec,
                                         input logic [OP_W-1:0] op, input logic [FN_W-1:0] fn);
        ctrl_out_t o;
        o = '0;
        case (st)
            ST_FETCH: begin
                o.iord = ADR_PC;
            end
            ST_FETCH_WAIT: begin
                o.ir_w        = 1'b1;
                o.alu_src_a   = SRCA_PC;
                o.alu_src_b   = SRCB_FOUR;
                o.alu_control = ALU_ADD;
                o.pc_source   = PCS_ALU;
                o.pc_w        = 1'b1;
            end
            ST_DECODE: begin
                o.reg_ab_w      = 1'b1;
                o.alu_src_a     = SRCA_PC;
                o.alu_src_b     = SRCB_IMM_S2;
                o.alu_control   = ALU_ADD;
                o.alu_out_reg_w = 1'b1;
            end
            ST_EXEC_R: begin
                o.alu_src_a     = SRCA_REGA;
                o.alu_src_b     = SRCB_REGB;
                o.alu_out_reg_w = 1'b1;
                case (fn)
                    FN_SUB:  o.alu_control = ALU_SUB;
                    FN_AND:  o.alu_control = ALU_AND;
                    default: o.alu_control = ALU_ADD;
                endcase
            end
            ST_WB_R: begin
                o.reg_dst    = DST_RD;
                o.mem_to_reg = M2R_ALUOUT;
                o.rb_w       = 1'b1;
            end
            ST_EXEC_I, ST_ADDR: begin
                o.alu_src_a     = SRCA_REGA;
                o.alu_src_b     = SRCB_IMM;
                o.alu_control   = ALU_ADD;
                o.alu_out_reg_w = 1'b1;
            end
            ST_WB_I: begin
                o.reg_dst    = DST_RT;
                o.mem_to_reg = M2R_ALUOUT;
                o.rb_w       = 1'b1;
            end
            ST_MEM_RD: begin
                o.iord = ADR_ALUOUT;
            end
            ST_MEM_WAIT: begin
                o.mdr_w = 1'b1;
            end
            ST_WB_LW: begin
                o.reg_dst    = DST_RT;
                o.mem_to_reg = M2R_MDR;
                o.rb_w       = 1'b1;
            end
            ST_MEM_WR: begin
                o.iord  = ADR_ALUOUT;
                o.mem_w = 1'b1;
            end
            ST_BRANCH: begin
                o.alu_src_a     = SRCA_REGA;
                o.alu_src_b     = SRCB_REGB;
                o.alu_control   = ALU_CMP;
                o.pc_write_cond = 1'b1;
                o.pc_source     = PCS_ALUOUT;
                o.cb            = (op == OP_BNE) ? CB_NE : CB_EQ;
            end
            ST_JUMP: begin
                o.pc_source = PCS_JUMP;
                o.pc_w      = 1'b1;
            end
            ST_EXC_SAVE: begin
                o.epc_w   = 1'b1;
                o.ec_ctrl = ec;
                o.iord    = ADR_EXC;
            end
            ST_EXC_WAIT: begin
                o.iord    = ADR_EXC;
                o.mdr_w   = 1'b1;
                o.ec_ctrl = ec;
            end
            ST_EXC_JUMP: begin
                o.pc_source = PCS_MDR;
                o.pc_w      = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

    // Next-state, exception cause and next control word
    always_comb begin
        nxt_state = state;
        nxt_cause = cause;
        case (state)
            ST_RESET:      nxt_state = ST_FETCH;
            ST_FETCH:      nxt_state = ST_FETCH_WAIT;
            ST_FETCH_WAIT: nxt_state = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (rtype_valid(funct)) begin
                            nxt_state = ST_EXEC_R;
                        end else begin
                            nxt_state = ST_EXC_SAVE;
                            nxt_cause = EC_BAD_OP;
                        end
                    end
                    OP_ADDI:        nxt_state = ST_EXEC_I;
                    OP_LW, OP_SW:   nxt_state = ST_ADDR;
                    OP_BEQ, OP_BNE: nxt_state = ST_BRANCH;
                    OP_J:           nxt_state = ST_JUMP;
                    default: begin
                        nxt_state = ST_EXC_SAVE;
                        nxt_cause = EC_BAD_OP;
                    end
                endcase
            end
            // AND cannot overflow, so its flag is ignored
            ST_EXEC_R: begin
                if (Flag_Overflow && (funct != FN_AND)) begin
                    nxt_state = ST_EXC_SAVE;
                    nxt_cause = EC_OVF;
                end else begin
                    nxt_state = ST_WB_R;
                end
            end
            ST_EXEC_I: begin
                if (Flag_Overflow) begin
                    nxt_state = ST_EXC_SAVE;
                    nxt_cause = EC_OVF;
                end else begin
                    nxt_state = ST_WB_I;
                end
            end
            ST_ADDR:      nxt_state = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:    nxt_state = ST_MEM_WAIT;
            ST_MEM_WAIT:  nxt_state = ST_WB_LW;
            ST_EXC_SAVE:  nxt_state = ST_EXC_WAIT;
            ST_EXC_WAIT:  nxt_state = ST_EXC_JUMP;
            ST_EXC_JUMP: begin
                nxt_state = ST_FETCH;
                nxt_cause = EC_NONE;
            end
            ST_WB_R, ST_WB_I, ST_WB_LW, ST_MEM_WR, ST_BRANCH, ST_JUMP: nxt_state = ST_FETCH;
            default:      nxt_state = ST_RESET;
        endcase
        nxt_out = decode(nxt_state, nxt_cause, opcode, funct);
    end

    // State, cause and registered control word; reset clears all outputs at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RESET;
            cause <= EC_NONE;
            out_q <= '0;
        end else begin
            state <= nxt_state;
            cause <= nxt_cause;
            out_q <= nxt_out;
        end
    end

    assign PC_W          = out_q.pc_w;
    assign PCWriteCond   = out_q.pc_write_cond;
    assign CB            = out_q.cb;
    assign PCSource      = out_q.pc_source;
    assign IorD          = out_q.iord;
    assign Mem_W         = out_q.mem_w;
    assign MDR_W         = out_q.mdr_w;
    assign IR_W          = out_q.ir_w;
    assign Reg_AB_W      = out_q.reg_ab_w;
    assign ALU_Out_Reg_W = out_q.alu_out_reg_w;
    assign RB_W          = out_q.rb_w;
    assign EPC_W         = out_q.epc_w;
    assign ALUSrcA       = out_q.alu_src_a;
    assign ALUSrcB       = out_q.alu_src_b;
    assign ALUControl    = out_q.alu_control;
    assign regDST        = out_q.reg_dst;
    assign MemToReg      = out_q.mem_to_reg;
    assign EC_CTRL       = out_q.ec_ctrl;

endmodule
